// File: rtl/col_dct8.sv
`timescale 1ns/1ps
// col_dct8: serial 8-point 1-D forward DCT, column pass of the 8x8 2-D DCT.
// Latency: x(k) captured on enabled cycle t appears as F(k) on S_out after enabled cycle t+9.
// Backpressure: none; ena_in low freezes every register and holds all outputs.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (release synchronised internally)
//   ena_in   advance enable for the whole block
//   sob_in   start of column: S_in is x(0) (sampled only when ena_in=1)
//   S_in     signed input sample x(n)
//   S_out    signed saturated coefficient F(k), registered
//   sob_out  high while S_out shows F(0)
//   vld_out  high while S_out shows a valid coefficient
module col_dct8 #(
    parameter int IN_W      = 12,
    parameter int OUT_W     = 12,
    parameter int COEF_FRAC = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena_in,
    input  logic                    sob_in,
    input  logic signed [IN_W-1:0]  S_in,
    output logic signed [OUT_W-1:0] S_out,
    output logic                    sob_out,
    output logic                    vld_out
);

    localparam int COEF_W = COEF_FRAC + 2;
    localparam int PROD_W = IN_W + COEF_W;
    localparam int ACC_W  = IN_W + COEF_FRAC + 5;

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(2 ** (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    // Coefficient ROM C[k][n] = round(2^13 * c(k)/2 * cos((2n+1)k*pi/16)).
    // The phase index m = (2n+1)k mod 32 is folded onto the first quadrant,
    // so only eight magnitudes are stored. Magnitudes are for COEF_FRAC=13.
    function automatic logic signed [COEF_W-1:0] coef(input logic [2:0] k, input logic [2:0] n);
        logic [4:0]  m;
        logic        neg;
        logic [12:0] mag;
        m = {1'b0, n, 1'b1} * {2'b00, k};
        if (m > 5'd16) begin
            m = 5'd0 - m;               // cos(2pi - a) = cos(a)
        end
        neg = (m > 5'd8);
        if (neg) begin
            m = 5'd16 - m;              // cos(pi - a) = -cos(a)
        end
        case (m)
            5'd0:    mag = 13'd4096;
            5'd1:    mag = 13'd4017;
            5'd2:    mag = 13'd3784;
            5'd3:    mag = 13'd3406;
            5'd4:    mag = 13'd2896;
            5'd5:    mag = 13'd2276;
            5'd6:    mag = 13'd1567;
            5'd7:    mag = 13'd799;
            default: mag = 13'd0;
        endcase
        if (k == 3'd0) begin
            mag = 13'd2896;             // DC row carries the extra 1/sqrt2
            neg = 1'b0;
        end
        coef = neg ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
    endfunction

    // Round half up, then clamp to the output range.
    function automatic logic signed [OUT_W-1:0] rnd_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = (a + RND) >>> COEF_FRAC;
        if (r > OUT_MAX) begin
            rnd_sat = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (r < OUT_MIN) begin
            rnd_sat = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            rnd_sat = r[OUT_W-1:0];
        end
    endfunction

    // Reset asserts asynchronously, releases on a clock edge.
    logic rst_meta;
    logic rst_sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    logic        [2:0]        n_cnt;
    logic        [2:0]        n_use;
    logic        [2:0]        prod_n;
    logic signed [PROD_W-1:0] prod [8];
    logic signed [ACC_W-1:0]  acc  [8];
    logic                     acc_done;
    logic signed [OUT_W-1:0]  bank [7];
    logic        [2:0]        out_cnt;
    logic                     out_act;

    // sob_in forces the sample to n=0; a cut column then simply restarts.
    assign n_use = sob_in ? 3'd0 : n_cnt;

    // Multiply stage: all eight products of the current sample.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            n_cnt  <= 3'd0;
            prod_n <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                prod[k] <= '0;
            end
        end else if (ena_in) begin
            n_cnt  <= n_use + 3'd1;
            prod_n <= n_use;
            for (int k = 0; k < 8; k++) begin
                prod[k] <= PROD_W'(coef(3'(k), n_use)) * PROD_W'(S_in);
            end
        end
    end

    // Accumulate stage. A product tagged n=0 restarts the sum, so a column
    // cut short never reaches n=7 and never produces output.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            acc_done <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                acc[k] <= '0;
            end
        end else if (ena_in) begin
            acc_done <= (prod_n == 3'd7);
            for (int k = 0; k < 8; k++) begin
                acc[k] <= (prod_n == 3'd0) ? ACC_W'(prod[k]) : acc[k] + ACC_W'(prod[k]);
            end
        end
    end

    // Output stage. F(0) goes straight out while F(1..7) park in a shift
    // bank; this edge also performs the next column's first accumulate,
    // so the bank takes the pre-edge sums.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            S_out   <= '0;
            sob_out <= 1'b0;
            vld_out <= 1'b0;
            out_cnt <= 3'd0;
            out_act <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                bank[i] <= '0;
            end
        end else if (ena_in) begin
            if (acc_done) begin
                S_out   <= rnd_sat(acc[0]);
                sob_out <= 1'b1;
                vld_out <= 1'b1;
                out_cnt <= 3'd1;
                out_act <= 1'b1;
                for (int k = 1; k < 8; k++) begin
                    bank[k-1] <= rnd_sat(acc[k]);
                end
            end else if (out_act) begin
                S_out   <= bank[0];
                sob_out <= 1'b0;
                vld_out <= 1'b1;
                out_cnt <= out_cnt + 3'd1;
                out_act <= (out_cnt != 3'd7);
                for (int i = 0; i < 6; i++) begin
                    bank[i] <= bank[i+1];
                end
            end else begin
                sob_out <= 1'b0;
                vld_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_col_dct8.sv
`timescale 1ns/1ps
// tb_col_dct8: directed and random columns through col_dct8.
// Expected coefficients are queued with the enabled-cycle index they are due on;
// a separate monitor pops and compares on every enabled cycle.
module tb_col_dct8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               ena_in;
    logic               sob_in;
    logic signed [11:0] S_in;
    logic signed [11:0] S_out;
    logic               sob_out;
    logic               vld_out;

    col_dct8 #(.IN_W(12), .OUT_W(12), .COEF_FRAC(13)) dut (
        .clk(clk), .rst_n(rst_n), .ena_in(ena_in), .sob_in(sob_in),
        .S_in(S_in), .S_out(S_out), .sob_out(sob_out), .vld_out(vld_out)
    );

    // Coefficient table C[k][n], written out row by row.
    localparam int CT [8][8] = '{
        '{ 2896,  2896,  2896,  2896,  2896,  2896,  2896,  2896},
        '{ 4017,  3406,  2276,   799,  -799, -2276, -3406, -4017},
        '{ 3784,  1567, -1567, -3784, -3784, -1567,  1567,  3784},
        '{ 3406,  -799, -4017, -2276,  2276,  4017,   799, -3406},
        '{ 2896, -2896, -2896,  2896,  2896, -2896, -2896,  2896},
        '{ 2276, -4017,   799,  3406, -3406,  -799,  4017, -2276},
        '{ 1567, -3784,  3784, -1567, -1567,  3784, -3784,  1567},
        '{  799, -2276,  3406, -4017,  4017, -3406,  2276,  -799}
    };

    typedef struct {
        int due;
        int val;
        bit sob;
    } exp_t;

    exp_t q[$];
    int   ecnt   = 0;
    int   last_e = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (e-cycle %0d)", name, act, exp_v, ecnt);
        end
    endtask

    function automatic int model(input int x[8], input int k);
        longint acc;
        acc = 0;
        for (int n = 0; n < 8; n++) begin
            acc += longint'(CT[k][n]) * longint'(x[n]);
        end
        acc = (acc + 4096) >>> 13;
        if (acc > 2047) return 2047;
        if (acc < -2048) return -2048;
        return int'(acc);
    endfunction

    // Monitor: counts enabled edges, checks outputs at the following negedge.
    initial begin : monitor
        bit e;
        bit exp_v;
        int ps;
        int psob;
        int pvld;
        ps = 0; psob = 0; pvld = 0;
        forever begin
            @(posedge clk);
            e = (ena_in === 1'b1) && (rst_n === 1'b1);
            if (e) ecnt++;
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                ps = S_out; psob = sob_out; pvld = vld_out;
                continue;
            end
            if (e) begin
                exp_v = (q.size() > 0) && (q[0].due == ecnt);
                chk("vld_out", vld_out, exp_v);
                if (exp_v) begin
                    if (vld_out) begin
                        chk("S_out", S_out, q[0].val);
                        chk("sob_out", sob_out, q[0].sob);
                    end
                    void'(q.pop_front());
                end
            end else begin
                chk("hold_S_out", S_out, ps);
                chk("hold_sob_out", sob_out, psob);
                chk("hold_vld_out", vld_out, pvld);
            end
            ps = S_out; psob = sob_out; pvld = vld_out;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    // One enabled sample; last_e is the e-cycle index on which it is captured.
    task automatic drive(input bit sob, input int x);
        @(posedge clk); #1;
        ena_in = 1'b1;
        sob_in = sob;
        S_in   = 12'(x);
        last_e = ecnt + 1;
    endtask

    // Disabled cycle with junk on the data inputs.
    task automatic idle();
        @(posedge clk); #1;
        ena_in = 1'b0;
        sob_in = 1'($urandom_range(0, 1));
        S_in   = 12'($urandom);
    endtask

    task automatic send_col(input int x[8], input int f[8], input bit sob0, input bit gaps);
        for (int n = 0; n < 8; n++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) idle();
            end
            drive((n == 0) ? sob0 : 1'b0, x[n]);
            if (n == 0) begin
                for (int k = 0; k < 8; k++) begin
                    q.push_back('{last_e + 9 + k, f[k], (k == 0)});
                end
            end
        end
    endtask

    // Flush with columns that are always cut after four samples.
    task automatic drain();
        for (int i = 0; i < 16; i++) begin
            drive((i % 4) == 0, int'($urandom_range(0, 4095)) - 2048);
        end
    endtask

    initial begin : stimulus
        int x[8];
        int f[8];

        rst_n = 1'b0; ena_in = 1'b0; sob_in = 1'b0; S_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_S_out", S_out, 0);
        chk("reset_sob_out", sob_out, 0);
        chk("reset_vld_out", vld_out, 0);
        rst_n = 1'b1;
        repeat (3) idle();

        // Constant, saturating and impulse columns, back to back.
        x = '{default: 100};
        f = '{283, 0, 0, 0, 0, 0, 0, 0};
        send_col(x, f, 1'b1, 1'b0);
        x = '{default: 2047};
        f = '{2047, 0, 0, 0, 0, 0, 0, 0};
        send_col(x, f, 1'b1, 1'b0);
        x = '{default: -2048};
        f = '{-2048, 0, 0, 0, 0, 0, 0, 0};
        send_col(x, f, 1'b0, 1'b0);
        x = '{1000, 0, 0, 0, 0, 0, 0, 0};
        f = '{354, 490, 462, 416, 354, 278, 191, 98};
        send_col(x, f, 1'b1, 1'b0);
        x = '{0, -1000, 0, 0, 0, 0, 0, 0};
        f = '{-354, -416, -191, 98, 354, 490, 462, 278};
        send_col(x, f, 1'b1, 1'b0);
        drain();

        // Column cut by sob_in at n=4 is dropped; the restarted one completes.
        for (int n = 0; n < 4; n++) begin
            drive(n == 0, 700 - 300 * n);
        end
        x = '{1000, 0, 0, 0, 0, 0, 0, 0};
        f = '{354, 490, 462, 416, 354, 278, 191, 98};
        send_col(x, f, 1'b1, 1'b0);
        drain();

        // Random columns, streamed with random enable gaps.
        for (int c = 0; c < 100; c++) begin
            for (int n = 0; n < 8; n++) begin
                if ($urandom_range(0, 7) == 0) begin
                    x[n] = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
                end else begin
                    x[n] = int'($urandom_range(0, 4095)) - 2048;
                end
            end
            for (int k = 0; k < 8; k++) begin
                f[k] = model(x, k);
            end
            send_col(x, f, (c == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();

        // Reset while one column streams out and the next is half captured.
        x = '{default: 100};
        f = '{283, 0, 0, 0, 0, 0, 0, 0};
        send_col(x, f, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            drive(1'b0, 37 * n - 90);
        end
        @(posedge clk); #1;
        rst_n  = 1'b0;
        ena_in = 1'b0;
        q.delete();
        #1;
        chk("midrst_S_out", S_out, 0);
        chk("midrst_sob_out", sob_out, 0);
        chk("midrst_vld_out", vld_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) idle();
        x = '{1000, 0, 0, 0, 0, 0, 0, 0};
        f = '{354, 490, 462, 416, 354, 278, 191, 98};
        send_col(x, f, 1'b1, 1'b1);
        drain();

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
